// File: rtl/cpu_oci_pkg.sv
// Shared definitions for the CPU on-chip-instrumentation trace path:
// atom geometry, atom encodings and the DCT packer state type.
package cpu_oci_pkg;

    localparam int ATOM_W  = 2;
    localparam int DEPTH   = 15;
    localparam int BUF_W   = ATOM_W * DEPTH;
    localparam int CNT_W   = 4;
    localparam int FRAME_W = CNT_W + BUF_W;

    localparam logic [ATOM_W-1:0] ATOM_NONE = 2'b00;
    localparam logic [ATOM_W-1:0] ATOM_LD   = 2'b01;
    localparam logic [ATOM_W-1:0] ATOM_ST   = 2'b10;
    localparam logic [ATOM_W-1:0] ATOM_ADDR = 2'b11;

    typedef enum logic {
        FILL      = 1'b0,
        FULL_WAIT = 1'b1
    } dct_state_e;

endpackage

// File: rtl/cpu_oci_dct_frame_slot.sv
// Single-entry valid/ready output register holding one {count, buffer} frame.
// A load replaces the slot contents; the slot empties when the frame is taken.
module cpu_oci_dct_frame_slot
    import cpu_oci_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_data,
    input  logic               frame_ready,
    output logic               frame_valid,
    output logic [FRAME_W-1:0] frame_data,
    output logic               slot_free
);

    assign slot_free = !frame_valid || frame_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_valid <= 1'b0;
            frame_data  <= '0;
        end else if (load) begin
            frame_valid <= 1'b1;
            frame_data  <= load_data;
        end else if (slot_free) begin
            // Data is left as-is; only the qualifier drops once the frame is taken.
            frame_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_oci_dct_packer.sv
// DCT packing stage: shifts 2-bit trace atoms into a 30-bit buffer and hands
// full or flushed frames to the trace-memory writer through a one-entry slot.
module cpu_oci_dct_packer
    import cpu_oci_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               trace_enable,
    input  logic               atom_valid,
    input  logic [ATOM_W-1:0]  atom,
    input  logic               flush,
    output logic [BUF_W-1:0]   dct_buffer,
    output logic [CNT_W-1:0]   dct_count,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic [FRAME_W-1:0] frame_data,
    output logic               overflow,
    input  logic               overflow_clr
);

    dct_state_e       state;
    logic             flush_pend;

    logic             accept;
    logic             drop;
    logic [BUF_W-1:0] buf_next;
    logic [CNT_W-1:0] cnt_next;
    logic             full_hit;
    logic             flush_hit;
    logic             transfer;
    logic             slot_free;

    // NOTE: every always_comb output gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        accept    = 1'b0;
        drop      = 1'b0;
        buf_next  = dct_buffer;
        cnt_next  = dct_count;
        full_hit  = 1'b0;
        flush_hit = 1'b0;
        transfer  = 1'b0;

        case (state)
            FILL: begin
                accept = atom_valid && trace_enable;
                if (accept) begin
                    buf_next = {dct_buffer[BUF_W-ATOM_W-1:0], atom};
                    cnt_next = dct_count + CNT_W'(1);
                end
                // The atom of this cycle is counted before the flush is judged.
                full_hit  = (cnt_next == CNT_W'(DEPTH));
                flush_hit = (flush || flush_pend) && (cnt_next != '0);
                transfer  = (full_hit || flush_hit) && slot_free;
            end
            FULL_WAIT: begin
                drop     = atom_valid && trace_enable;
                transfer = slot_free;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FILL;
            flush_pend <= 1'b0;
            dct_buffer <= '0;
            dct_count  <= '0;
            overflow   <= 1'b0;
        end else begin
            // A drop in the same cycle as a clear wins, so no loss goes unseen.
            overflow <= drop || (overflow && !overflow_clr);

            if (transfer) begin
                state      <= FILL;
                flush_pend <= 1'b0;
                dct_buffer <= '0;
                dct_count  <= '0;
            end else begin
                dct_buffer <= buf_next;
                dct_count  <= cnt_next;
                if (state == FILL && (full_hit || flush_hit)) begin
                    state      <= FULL_WAIT;
                    flush_pend <= flush_hit;
                end
            end
        end
    end

    cpu_oci_dct_frame_slot u_frame_slot (
        .clk         (clk),
        .reset       (reset),
        .load        (transfer),
        .load_data   ({cnt_next, buf_next}),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .slot_free   (slot_free)
    );

endmodule

// File: tb/tb_cpu_oci_dct_packer.sv
// Self-checking bench for cpu_oci_dct_packer: directed scenarios plus a random
// run compared against an atom-queue reference model.
module tb_cpu_oci_dct_packer;
    import cpu_oci_pkg::*;

    logic               clk;
    logic               reset;
    logic               trace_enable;
    logic               atom_valid;
    logic [ATOM_W-1:0]  atom;
    logic               flush;
    logic [BUF_W-1:0]   dct_buffer;
    logic [CNT_W-1:0]   dct_count;
    logic               frame_valid;
    logic               frame_ready;
    logic [FRAME_W-1:0] frame_data;
    logic               overflow;
    logic               overflow_clr;

    int total = 0;
    int bad   = 0;

    // Reference model: the partial frame is simply the ordered list of atoms.
    int                 q[$];
    bit                 m_blocked;
    bit                 m_fpend;
    bit                 m_fv;
    logic [FRAME_W-1:0] m_fd;
    bit                 m_ovf;

    cpu_oci_dct_packer dut (
        .clk          (clk),
        .reset        (reset),
        .trace_enable (trace_enable),
        .atom_valid   (atom_valid),
        .atom         (atom),
        .flush        (flush),
        .dct_buffer   (dct_buffer),
        .dct_count    (dct_count),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_data   (frame_data),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oldest atom ends up most significant: value = sum atom_i * 4^(n-1-i).
    function automatic logic [BUF_W-1:0] pack_q();
        logic [BUF_W-1:0] v = '0;
        foreach (q[i]) v = v * 4 + BUF_W'(q[i]);
        return v;
    endfunction

    task automatic model_step();
        bit slot_free, xfer, drop, full_hit, flush_hit;
        xfer = 0;
        drop = 0;
        if (reset) begin
            q.delete();
            m_blocked = 0; m_fpend = 0; m_fv = 0; m_fd = '0; m_ovf = 0;
            return;
        end
        slot_free = !m_fv || frame_ready;
        if (!m_blocked) begin
            if (atom_valid && trace_enable) q.push_back(int'(atom));
            full_hit  = (q.size() == DEPTH);
            flush_hit = (flush || m_fpend) && (q.size() > 0);
            if (full_hit || flush_hit) begin
                if (slot_free) xfer = 1;
                else begin
                    m_blocked = 1;
                    m_fpend   = flush_hit;
                end
            end
        end else begin
            drop = atom_valid && trace_enable;
            if (slot_free) xfer = 1;
        end
        if (xfer) begin
            m_fd = {CNT_W'(q.size()), pack_q()};
            m_fv = 1;
            q.delete();
            m_blocked = 0;
            m_fpend   = 0;
        end else if (slot_free) begin
            m_fv = 0;
        end
        if (drop) m_ovf = 1;
        else if (overflow_clr) m_ovf = 0;
    endtask

    // Inputs change at the falling edge; outputs are read at the next falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        atom_valid = 0; flush = 0; overflow_clr = 0; atom = ATOM_NONE;
    endtask

    task automatic feed(input int n, input logic [ATOM_W-1:0] a);
        for (int i = 0; i < n; i++) begin
            atom_valid = 1; atom = a;
            tick();
        end
        atom_valid = 0;
    endtask

    task automatic test_reset();
        reset = 1; trace_enable = 1; frame_ready = 0; idle_inputs();
        tick(); tick();
        reset = 0;
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
        total++; if (frame_data !== '0) begin bad++; $display("FAIL reset_fd: got %h want 0", frame_data); end
        total++; if (dct_count !== '0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", dct_count); end
        total++; if (dct_buffer !== '0) begin bad++; $display("FAIL reset_buf: got %h want 0", dct_buffer); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_full_frame();
        frame_ready = 1;
        feed(14, ATOM_LD);
        total++; if (dct_count !== 4'd14) begin bad++; $display("FAIL full_cnt14: got %0d want 14", dct_count); end
        feed(1, ATOM_LD);
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL full_fv: got %b want 1", frame_valid); end
        total++; if (frame_data !== {4'd15, 30'h15555555}) begin bad++; $display("FAIL full_fd: got %h want %h", frame_data, {4'd15, 30'h15555555}); end
        total++; if (dct_count !== 4'd0) begin bad++; $display("FAIL full_cnt0: got %0d want 0", dct_count); end
        tick();
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL full_drain: got %b want 0", frame_valid); end
    endtask

    task automatic test_flush();
        frame_ready = 1;
        feed(5, ATOM_ADDR);
        flush = 1; tick(); flush = 0;
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL flush_fv: got %b want 1", frame_valid); end
        total++; if (frame_data !== {4'd5, 30'h000003FF}) begin bad++; $display("FAIL flush_fd: got %h want %h", frame_data, {4'd5, 30'h000003FF}); end
        flush = 1; tick(); flush = 0;
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL flush_empty: got %b want 0", frame_valid); end
        tick();
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL flush_empty2: got %b want 0", frame_valid); end
    endtask

    task automatic test_trace_disable();
        frame_ready = 1;
        feed(3, ATOM_LD);
        trace_enable = 0;
        feed(5, ATOM_ADDR);
        total++; if (dct_count !== 4'd3) begin bad++; $display("FAIL dis_cnt: got %0d want 3", dct_count); end
        total++; if (dct_buffer !== 30'h15) begin bad++; $display("FAIL dis_buf: got %h want 15", dct_buffer); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL dis_ovf: got %b want 0", overflow); end
        flush = 1; tick(); flush = 0;
        total++; if (frame_data !== {4'd3, 30'h15} || frame_valid !== 1'b1) begin bad++; $display("FAIL dis_flush: got %b/%h want 1/%h", frame_valid, frame_data, {4'd3, 30'h15}); end
        trace_enable = 1;
        tick();
    endtask

    task automatic test_back_to_back();
        frame_ready = 0;
        feed(15, ATOM_ST);
        total++; if (frame_valid !== 1'b1 || frame_data !== {4'd15, 30'h2AAAAAAA}) begin bad++; $display("FAIL b2b_f1: got %b/%h want 1/%h", frame_valid, frame_data, {4'd15, 30'h2AAAAAAA}); end
        feed(15, ATOM_ADDR);
        total++; if (dct_count !== 4'd15) begin bad++; $display("FAIL b2b_hold_cnt: got %0d want 15", dct_count); end
        total++; if (frame_data !== {4'd15, 30'h2AAAAAAA}) begin bad++; $display("FAIL b2b_stable: got %h want %h", frame_data, {4'd15, 30'h2AAAAAAA}); end
        feed(1, ATOM_LD);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL b2b_ovf: got %b want 1", overflow); end
        total++; if (dct_buffer !== 30'h3FFFFFFF) begin bad++; $display("FAIL b2b_hold_buf: got %h want 3fffffff", dct_buffer); end
        frame_ready = 1; tick();
        total++; if (frame_valid !== 1'b1 || frame_data !== {4'd15, 30'h3FFFFFFF}) begin bad++; $display("FAIL b2b_f2: got %b/%h want 1/%h", frame_valid, frame_data, {4'd15, 30'h3FFFFFFF}); end
        total++; if (dct_count !== 4'd0) begin bad++; $display("FAIL b2b_cnt0: got %0d want 0", dct_count); end
        tick();
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", frame_valid); end
        overflow_clr = 1; tick(); overflow_clr = 0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_clr: got %b want 0", overflow); end
    endtask

    task automatic test_atom_flush();
        frame_ready = 1;
        feed(14, ATOM_LD);
        atom_valid = 1; atom = ATOM_ST; flush = 1;
        tick();
        idle_inputs();
        total++; if (frame_valid !== 1'b1 || frame_data !== {4'd15, 30'h15555556}) begin bad++; $display("FAIL af_frame: got %b/%h want 1/%h", frame_valid, frame_data, {4'd15, 30'h15555556}); end
        total++; if (dct_count !== 4'd0) begin bad++; $display("FAIL af_cnt: got %0d want 0", dct_count); end
        tick();
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL af_no_second: got %b want 0", frame_valid); end
    endtask

    task automatic test_reset_mid_fill();
        frame_ready = 0;
        feed(15, ATOM_LD);
        feed(4, ATOM_ADDR);
        total++; if (frame_valid !== 1'b1 || dct_count !== 4'd4) begin bad++; $display("FAIL rmf_pre: got %b/%0d want 1/4", frame_valid, dct_count); end
        reset = 1; tick(); reset = 0;
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL rmf_fv: got %b want 0", frame_valid); end
        total++; if (dct_count !== 4'd0 || dct_buffer !== '0) begin bad++; $display("FAIL rmf_buf: got %0d/%h want 0/0", dct_count, dct_buffer); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rmf_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_overflow_clr();
        frame_ready = 0;
        feed(30, ATOM_LD);
        atom_valid = 1; atom = ATOM_ST; overflow_clr = 1;
        tick();
        atom_valid = 0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
        tick();
        overflow_clr = 0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %b want 0", overflow); end
        frame_ready = 1; tick(); tick();
        total++; if (frame_valid !== 1'b0 || dct_count !== 4'd0) begin bad++; $display("FAIL ovf_drain: got %b/%0d want 0/0", frame_valid, dct_count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(199) == 0);
            trace_enable = ($urandom_range(9) < 8);
            atom_valid   = ($urandom_range(9) < 6);
            atom         = ATOM_W'($urandom_range(3));
            flush        = ($urandom_range(9) == 0);
            frame_ready  = ($urandom_range(9) < 4);
            overflow_clr = ($urandom_range(19) == 0);
            tick();
            total++; if (dct_buffer !== pack_q()) begin bad++; $display("FAIL rnd_buf @%0d: got %h want %h", i, dct_buffer, pack_q()); end
            total++; if (dct_count !== CNT_W'(q.size())) begin bad++; $display("FAIL rnd_cnt @%0d: got %0d want %0d", i, dct_count, q.size()); end
            total++; if (frame_valid !== m_fv) begin bad++; $display("FAIL rnd_fv @%0d: got %b want %b", i, frame_valid, m_fv); end
            total++; if (frame_data !== m_fd) begin bad++; $display("FAIL rnd_fd @%0d: got %h want %h", i, frame_data, m_fd); end
            total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf @%0d: got %b want %b", i, overflow, m_ovf); end
        end
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_flush();
        test_trace_disable();
        test_back_to_back();
        test_atom_flush();
        test_reset_mid_fill();
        test_overflow_clr();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_oci_dct_packer.md
Name: cpu_oci_dct_packer

Overview:
- Data-capture-trace (DCT) packing stage of the CPU on-chip-instrumentation block.
- Accepts 2-bit trace atoms from the OCI trace generator and packs up to 15 of them into a 30-bit buffer.
- Hands completed or flushed frames to the trace-memory writer over a valid/ready handshake.
- Exposes the live dct_buffer/dct_count pair consumed by the OCI test-bench monitor.

Parameters:
- ATOM_W, 2, bits per trace atom.
- DEPTH, 15, atoms per full frame.
- BUF_W, 30, buffer width; must equal ATOM_W*DEPTH.
- CNT_W, 4, count width; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- trace_enable  in  1  atoms are accepted only while high.
- atom_valid  in  1  atom qualifier.
- atom  in  ATOM_W  trace atom.
- flush  in  1  single-cycle request to emit a partial frame.
- dct_buffer  out  BUF_W  live packing buffer.
- dct_count  out  CNT_W  number of atoms in dct_buffer.
- frame_valid  out  1  frame slot holds a frame.
- frame_ready  in  1  downstream accepts the frame.
- frame_data  out  CNT_W+BUF_W  frame payload, {count, buffer}.
- overflow  out  1  sticky: an atom was dropped.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Reset: all outputs are 0, flush_pend=0, FSM=FILL. Reset mid-frame discards the buffer and the frame slot contents without emitting them.
- accept = atom_valid & trace_enable & (state==FILL).
- On accept: dct_buffer <= {dct_buffer[BUF_W-ATOM_W-1:0], atom}, so the newest atom sits at the LSBs. dct_count increments.
- slot_free = !frame_valid | frame_ready.
- A frame transfer loads frame_data and sets frame_valid=1, and clears dct_buffer/dct_count in the same cycle.
- If slot_free occurs without a transfer, frame_valid <= 0 on the next edge.

FSM states:
- FILL: normal packing.
  - If the count after an accept equals DEPTH:
    - slot_free -> transfer in the same cycle. The frame is visible the next cycle, one cycle latency from the 15th atom.
    - Otherwise -> FULL_WAIT, holding buffer/count at 15.
  - flush (or flush_pend) with post-accept count > 0:
    - slot_free -> transfer, clear flush_pend.
    - Otherwise -> set flush_pend, go to FULL_WAIT.
  - flush with count 0 is ignored; no frame is produced.
- FULL_WAIT: accept is 0.
  - Any atom_valid & trace_enable sets overflow; the atom is dropped.
  - When slot_free: transfer, return to FILL, clear flush_pend.
- Same cycle atom+flush: the atom is appended first, then the flush applies. Count 14 + atom + flush yields a count-15 frame.
- Flush arriving in FULL_WAIT is absorbed, because the pending frame is emitted anyway.
- Back-to-back frames: the slot is reloaded in the same cycle frame_ready is sampled high, so there are no bubbles.
- overflow: set has priority over overflow_clr when both occur in the same cycle.
- frame_data and frame_valid are stable while frame_valid & !frame_ready.
- trace_enable low: atoms are ignored and overflow is not set in FILL; a buffered partial frame is retained.

Decomposition:
- Shared package cpu_oci_pkg holds:
  - ATOM_W, DEPTH, BUF_W, CNT_W.
  - The atom encoding constants: ATOM_NONE=2'b00, ATOM_LD=2'b01, ATOM_ST=2'b10, ATOM_ADDR=2'b11.
  - The FSM state enum {FILL, FULL_WAIT}.
- One natural sub-module: cpu_oci_dct_frame_slot, the single-entry valid/ready output register.

Test Plan:
- Reset, then 15 accepted atoms with value 2'b01, frame_ready=1 -> after the 15th edge: frame_valid=1, frame_data={4'd15, 30'h15555555}, dct_count=0.
- 5 atoms 2'b11, then flush -> frame_data={4'd5, 30'h000003FF} one cycle later. A subsequent flush with count 0 produces no frame.
- frame_ready=0 while two frames complete -> second fill holds in FULL_WAIT at count 15. A 31st atom sets overflow=1. Raising frame_ready drains frame 1, then frame 2 on the next cycle.
- 14 atoms, then atom 2'b10 together with flush in one cycle -> a single frame with count 15, LSBs 2'b10; no second partial frame.
- Frame pending with frame_ready=0, assert reset mid-fill -> next cycle frame_valid=0, dct_count=0, overflow=0.
- overflow set and overflow_clr in the same cycle as a dropped atom -> overflow stays 1. overflow_clr alone in the next cycle -> overflow=0.
